// File: rtl/ascon_seq_ctrl.sv
// rtl/ascon_seq_ctrl.sv - job sequencer for the bit-serial Ascon core
//
// Takes one parallel job (key, nonce, associated data, data block,
// direction) over a req valid/ready handshake. It shifts the job MSB-first
// onto the core's serial lanes, pulses core_start_so and waits for
// core_ready_si. It then collects the core's serial tag/data into parallel
// registers and returns them over a rsp valid/ready handshake.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       job handshake (req_ready high only when idle)
//   req_decrypt, req_key, req_nonce, req_ad, req_data   job fields
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_tag, rsp_err  response payload (rsp_err only with watchdog)
//   busy                      high whenever a job is in flight
//   core_*_so                 serial lanes, start pulse and direction to core
//   core_data_si, core_tag_si, core_ready_si   serial results / ready from core
//
// Optional feature macro: ASCON_SEQ_TIMEOUT_EN (watchdog on the WAIT state).

module ascon_seq_ctrl #(
    parameter int KEY_BITS    = 128,
    parameter int DATA_BITS   = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_decrypt,
    input  logic [KEY_BITS-1:0]  req_key,
    input  logic [KEY_BITS-1:0]  req_nonce,
    input  logic [DATA_BITS-1:0] req_ad,
    input  logic [DATA_BITS-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [KEY_BITS-1:0]  rsp_tag,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 core_key_so,
    output logic                 core_nonce_so,
    output logic                 core_ad_so,
    output logic                 core_data_so,
    output logic                 core_start_so,
    output logic                 core_decrypt_so,
    input  logic                 core_data_si,
    input  logic                 core_tag_si,
    input  logic                 core_ready_si
);

    localparam int CW = $clog2(KEY_BITS) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(KEY_BITS - 1);
    localparam logic [CW-1:0] DATA_LIM = CW'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Load shift registers: the lane outputs are their MSBs. They shift in
    // zeros, so each lane falls to 0 by itself once its bits are exhausted
    // (ad/data after DATA_BITS cycles, all lanes by the START cycle).
    logic [KEY_BITS-1:0]  key_sr_q, key_sr_d;
    logic [KEY_BITS-1:0]  nonce_sr_q, nonce_sr_d;
    logic [DATA_BITS-1:0] ad_sr_q, ad_sr_d;
    logic [DATA_BITS-1:0] din_sr_q, din_sr_d;

    // Capture shift registers double as the response registers; they only
    // move during capture, so the last response stays visible afterwards.
    logic [KEY_BITS-1:0]  tag_sr_q, tag_sr_d;
    logic [DATA_BITS-1:0] dout_sr_q, dout_sr_d;

    logic                 dir_q, dir_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 start_q, start_d;

`ifdef ASCON_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0]        wd_q, wd_d;
    logic                 rsp_err_q, rsp_err_d;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_sr_d   = key_sr_q;
        nonce_sr_d = nonce_sr_q;
        ad_sr_d    = ad_sr_q;
        din_sr_d   = din_sr_q;
        tag_sr_d   = tag_sr_q;
        dout_sr_d  = dout_sr_q;
        dir_d      = dir_q;
`ifdef ASCON_SEQ_TIMEOUT_EN
        wd_d       = wd_q;
        rsp_err_d  = rsp_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    key_sr_d   = req_key;
                    nonce_sr_d = req_nonce;
                    ad_sr_d    = req_ad;
                    din_sr_d   = req_data;
                    dir_d      = req_decrypt;
                end
            end

            S_LOAD: begin
                key_sr_d   = {key_sr_q[KEY_BITS-2:0], 1'b0};
                nonce_sr_d = {nonce_sr_q[KEY_BITS-2:0], 1'b0};
                ad_sr_d    = {ad_sr_q[DATA_BITS-2:0], 1'b0};
                din_sr_d   = {din_sr_q[DATA_BITS-2:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_START: begin
                state_d = S_WAIT;
`ifdef ASCON_SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end

            S_WAIT: begin
                // The cycle ready is first seen already carries capture bit 0.
                if (core_ready_si) begin
                    tag_sr_d  = {tag_sr_q[KEY_BITS-2:0], core_tag_si};
                    dout_sr_d = {dout_sr_q[DATA_BITS-2:0], core_data_si};
                    cnt_d     = CW'(1);
                    state_d   = S_CAPTURE;
                end
`ifdef ASCON_SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d   = S_DONE;
                    tag_sr_d  = '0;
                    dout_sr_d = '0;
                    rsp_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end

            S_CAPTURE: begin
                // Fixed-length capture: core_ready_si is no longer looked at.
                tag_sr_d = {tag_sr_q[KEY_BITS-2:0], core_tag_si};
                if (cnt_q < DATA_LIM) begin
                    dout_sr_d = {dout_sr_q[DATA_BITS-2:0], core_data_si};
                end
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                if (rsp_ready) begin
                    state_d   = S_IDLE;
                    dir_d     = 1'b0;
`ifdef ASCON_SEQ_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that they are
        // registered yet line up with the state they describe.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        start_d     = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_sr_q    <= '0;
            nonce_sr_q  <= '0;
            ad_sr_q     <= '0;
            din_sr_q    <= '0;
            tag_sr_q    <= '0;
            dout_sr_q   <= '0;
            dir_q       <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            start_q     <= 1'b0;
`ifdef ASCON_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_sr_q    <= key_sr_d;
            nonce_sr_q  <= nonce_sr_d;
            ad_sr_q     <= ad_sr_d;
            din_sr_q    <= din_sr_d;
            tag_sr_q    <= tag_sr_d;
            dout_sr_q   <= dout_sr_d;
            dir_q       <= dir_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            start_q     <= start_d;
`ifdef ASCON_SEQ_TIMEOUT_EN
            wd_q        <= wd_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready       = req_ready_q;
    assign busy            = busy_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_tag         = tag_sr_q;
    assign rsp_data        = dout_sr_q;
    assign core_key_so     = key_sr_q[KEY_BITS-1];
    assign core_nonce_so   = nonce_sr_q[KEY_BITS-1];
    assign core_ad_so      = ad_sr_q[DATA_BITS-1];
    assign core_data_so    = din_sr_q[DATA_BITS-1];
    assign core_start_so   = start_q;
    assign core_decrypt_so = dir_q;
`ifdef ASCON_SEQ_TIMEOUT_EN
    assign rsp_err         = rsp_err_q;
`else
    assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// tb/tb_ascon_seq_ctrl.sv - self-checking bench for ascon_seq_ctrl
module tb_ascon_seq_ctrl;

    localparam int KB = 128;
    localparam int DB = 64;
    localparam int TO = 16;

    localparam logic [KB-1:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [KB-1:0] N1 = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [DB-1:0] A1 = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [DB-1:0] D1 = 64'h0123456789ABCDEF;
    localparam logic [KB-1:0] T1 = 128'hFEDCBA9876543210F0E1D2C3B4A59610;
    localparam logic [DB-1:0] R1 = 64'h1122334455667788;

    localparam logic [KB-1:0] K2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [KB-1:0] N2 = 128'h55AA33CC0FF0A55A5AA5F00FCC33AA55;
    localparam logic [DB-1:0] A2 = 64'h0000FFFF0000FFFF;
    localparam logic [DB-1:0] D2 = 64'hDEADBEEFCAFEF00D;
    localparam logic [KB-1:0] T2 = 128'h0123456789ABCDEF8899AABBCCDDEEFF;
    localparam logic [DB-1:0] R2 = 64'h8877665544332211;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_decrypt = 1'b0;
    logic [KB-1:0] req_key = '0;
    logic [KB-1:0] req_nonce = '0;
    logic [DB-1:0] req_ad = '0;
    logic [DB-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DB-1:0] rsp_data;
    logic [KB-1:0] rsp_tag;
    logic          rsp_err;
    logic          busy;
    logic          core_key_so, core_nonce_so, core_ad_so, core_data_so;
    logic          core_start_so, core_decrypt_so;
    logic          core_data_si = 1'b0;
    logic          core_tag_si = 1'b0;
    logic          core_ready_si = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [KB-1:0] tag;
        logic [DB-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t last_exp;

    ascon_seq_ctrl #(
        .KEY_BITS   (KB),
        .DATA_BITS  (DB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_decrypt    (req_decrypt),
        .req_key        (req_key),
        .req_nonce      (req_nonce),
        .req_ad         (req_ad),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .core_key_so    (core_key_so),
        .core_nonce_so  (core_nonce_so),
        .core_ad_so     (core_ad_so),
        .core_data_so   (core_data_so),
        .core_start_so  (core_start_so),
        .core_decrypt_so(core_decrypt_so),
        .core_data_si   (core_data_si),
        .core_tag_si    (core_tag_si),
        .core_ready_si  (core_ready_si)
    );

    always #5 clk = ~clk;

    // Drives request fields; the caller decides when req_valid drops.
    task automatic offer(input logic [KB-1:0] k, input logic [KB-1:0] n,
                         input logic [DB-1:0] a, input logic [DB-1:0] d,
                         input logic dec);
        req_key     = k;
        req_nonce   = n;
        req_ad      = a;
        req_data    = d;
        req_decrypt = dec;
        req_valid   = 1'b1;
    endtask

    // Core model: called at the negedge of C0, streams KB result bits and
    // returns at the negedge of C0+KB. Ready and unused data bits after C0
    // are random, as the sequencer must ignore them.
    task automatic core_stream(input logic [KB-1:0] tag, input logic [DB-1:0] data,
                               output int early);
        rsp_t e;
        early  = 0;
        e.tag  = tag;
        e.data = data;
        e.err  = 1'b0;
        sb_q.push_back(e);
        for (int k = 0; k < KB; k++) begin
            core_ready_si = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            core_tag_si   = tag[KB-1-k];
            core_data_si  = (k < DB) ? data[DB-1-k] : 1'($urandom_range(0, 1));
            if (rsp_valid === 1'b1) early++;
            @(negedge clk);
        end
        core_ready_si = 1'b0;
        core_tag_si   = 1'b0;
        core_data_si  = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        got = {req_ready, busy, rsp_valid, rsp_err, core_start_so, core_decrypt_so,
               core_key_so, core_nonce_so, core_ad_so, core_data_so};
        n_vec++;
        if (got !== 10'b1000000000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", got, 10'b1000000000);
        end
        n_vec++;
        if (rsp_tag !== '0 || rsp_data !== '0) begin
            n_err++;
            $display("FAIL reset_rsp_regs: got tag %h data %h want zeros", rsp_tag, rsp_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = {req_ready, busy, rsp_valid, rsp_err, core_start_so, core_decrypt_so,
               core_key_so, core_nonce_so, core_ad_so, core_data_so};
        n_vec++;
        if (got !== 10'b1000000000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want %b", got, 10'b1000000000);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [5:0] got;
        int bad;
        offer('1, '1, '1, '1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        n_vec++;
        if (core_key_so !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_load_bit40: got key %b busy %b want 1 1", core_key_so, busy);
        end
        rst = 1'b0;
        #1;
        got = {req_ready, busy, core_key_so, core_nonce_so, core_ad_so, core_data_so};
        n_vec++;
        if (got !== 6'b100000) begin
            n_err++;
            $display("FAIL async_reset_mid_load: got %b want %b", got, 6'b100000);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL abandoned_job_no_rsp: got %0d busy/valid cycles want 0", bad);
        end
    endtask

    task automatic test_encrypt();
        logic [KB-1:0] k, n;
        logic [DB-1:0] a, d;
        logic [7:0] got, exp;
        int early, lat;
        rsp_t e;
        k = K1; n = N1; a = A1; d = D1;
        offer(K1, N1, A1, D1, 1'b0);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL enc_accept_ready: got %b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < KB; i++) begin
            exp = {k[KB-1-i], n[KB-1-i], (i < DB) ? a[DB-1-i] : 1'b0,
                   (i < DB) ? d[DB-1-i] : 1'b0, 4'b0010};
            got = {core_key_so, core_nonce_so, core_ad_so, core_data_so,
                   core_start_so, core_decrypt_so, busy, req_ready};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL enc_load i=%0d: got %b want %b", i, got, exp);
            end
            @(negedge clk);
        end
        got = {core_key_so, core_nonce_so, core_ad_so, core_data_so,
               core_start_so, core_decrypt_so, busy, req_ready};
        n_vec++;
        if (got !== 8'b00001010) begin
            n_err++;
            $display("FAIL enc_start_pulse: got %b want %b", got, 8'b00001010);
        end
        @(negedge clk);
        n_vec++;
        if (core_start_so !== 1'b0) begin
            n_err++;
            $display("FAIL enc_start_one_cycle: got %b want 0", core_start_so);
        end
        repeat (9) @(negedge clk);
        core_stream(T1, R1, early);
        n_vec++;
        if (early != 0) begin
            n_err++;
            $display("FAIL enc_early_valid: got %0d cycles want 0", early);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != 0) begin
            n_err++;
            $display("FAIL enc_rsp_latency: got %0d want %0d", KB + lat, KB);
        end
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL enc_scoreboard: got empty queue want 1 entry");
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            if (rsp_tag !== e.tag || rsp_data !== e.data || rsp_err !== e.err) begin
                n_err++;
                $display("FAIL enc_rsp: got %h %h %b want %h %h %b",
                         rsp_tag, rsp_data, rsp_err, e.tag, e.data, e.err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] got;
        for (int h = 0; h < 5; h++) begin
            n_vec++;
            if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0 ||
                rsp_tag !== last_exp.tag || rsp_data !== last_exp.data) begin
                n_err++;
                $display("FAIL hold_done h=%0d: got v%b b%b r%b %h %h want v1 b1 r0 %h %h",
                         h, rsp_valid, busy, req_ready, rsp_tag, rsp_data,
                         last_exp.tag, last_exp.data);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        got = {busy, req_ready, rsp_valid, core_decrypt_so};
        n_vec++;
        if (got !== 4'b0100) begin
            n_err++;
            $display("FAIL after_handshake: got %b want %b", got, 4'b0100);
        end
        n_vec++;
        if (rsp_tag !== last_exp.tag || rsp_data !== last_exp.data) begin
            n_err++;
            $display("FAIL rsp_kept: got %h %h want %h %h",
                     rsp_tag, rsp_data, last_exp.tag, last_exp.data);
        end
    endtask

    task automatic test_decrypt_busy();
        logic [KB-1:0] k, n;
        logic [DB-1:0] a, d;
        logic [6:0] got, exp;
        int early, lat;
        rsp_t e;
        k = K2; n = N2; a = A2; d = D2;
        offer(K2, N2, A2, D2, 1'b1);
        @(negedge clk);
        // A competing job stays offered during the whole load phase.
        offer(~K2, ~N2, ~A2, ~D2, 1'b0);
        for (int i = 0; i < KB; i++) begin
            exp = {k[KB-1-i], n[KB-1-i], (i < DB) ? a[DB-1-i] : 1'b0,
                   (i < DB) ? d[DB-1-i] : 1'b0, 3'b100};
            got = {core_key_so, core_nonce_so, core_ad_so, core_data_so,
                   core_decrypt_so, core_start_so, req_ready};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL dec_load_busy i=%0d: got %b want %b", i, got, exp);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_vec++;
        if (core_start_so !== 1'b1 || core_decrypt_so !== 1'b1) begin
            n_err++;
            $display("FAIL dec_start: got start %b dir %b want 1 1", core_start_so, core_decrypt_so);
        end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            n_vec++;
            if (core_decrypt_so !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL dec_wait w=%0d: got dir %b busy %b want 1 1", w, core_decrypt_so, busy);
            end
        end
        rsp_ready = 1'b1;
        core_stream(T2, R2, early);
        n_vec++;
        if (early != 0) begin
            n_err++;
            $display("FAIL dec_early_valid: got %0d cycles want 0", early);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != 0 || core_decrypt_so !== 1'b1) begin
            n_err++;
            $display("FAIL dec_done: got latency %0d dir %b want %0d 1", KB + lat, core_decrypt_so, KB);
        end
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL dec_scoreboard: got empty queue want 1 entry");
        end else begin
            e = sb_q.pop_front();
            if (rsp_tag !== e.tag || rsp_data !== e.data || rsp_err !== e.err) begin
                n_err++;
                $display("FAIL dec_rsp: got %h %h %b want %h %h %b",
                         rsp_tag, rsp_data, rsp_err, e.tag, e.data, e.err);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, busy, req_ready, core_decrypt_so} !== 4'b0010) begin
            n_err++;
            $display("FAIL dec_first_cycle_handshake: got %b want %b",
                     {rsp_valid, busy, req_ready, core_decrypt_so}, 4'b0010);
        end
    endtask

`ifdef ASCON_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        rsp_t e;
        offer(K1, N1, A1, D1, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (KB) @(negedge clk);
        @(negedge clk);
        e.tag  = '0;
        e.data = '0;
        e.err  = 1'b1;
        sb_q.push_back(e);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != TO) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d want %0d", lat, TO);
        end
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL timeout_scoreboard: got empty queue want 1 entry");
        end else begin
            e = sb_q.pop_front();
            if (rsp_tag !== e.tag || rsp_data !== e.data || rsp_err !== e.err) begin
                n_err++;
                $display("FAIL timeout_rsp: got %h %h %b want %h %h %b",
                         rsp_tag, rsp_data, rsp_err, e.tag, e.data, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++;
        if (rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_err_clear: got err %b ready %b want 0 1", rsp_err, req_ready);
        end
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_reset_mid_load();
        @(negedge clk);
        test_encrypt();
        test_backpressure();
        @(negedge clk);
        test_decrypt_busy();
`ifdef ASCON_SEQ_TIMEOUT_EN
        @(negedge clk);
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL global_time_limit: got no completion want finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule

// File: doc/ascon_seq_ctrl.md
Name: ascon_seq_ctrl

Overview:
- Sequencer for the bit-serial Ascon core.
- Accepts one parallel job (key, nonce, associated data, data block, direction) over a valid/ready handshake.
- Serialises the job onto the core's serial inputs, pulses start, and waits for ready.
- Deserialises the core's serial data and tag outputs into parallel response registers, returned over a second valid/ready handshake.

Parameters:
KEY_BITS, 128, key/nonce/tag width; also the load-phase length in cycles
DATA_BITS, 64, width of the data and associated-data blocks (must be <= KEY_BITS)
TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with ASCON_SEQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  1  job offered
req_ready  output  1  controller can accept a job (high only in IDLE)
req_decrypt  input  1  1 = decrypt, 0 = encrypt
req_key  input  KEY_BITS  key
req_nonce  input  KEY_BITS  nonce
req_ad  input  DATA_BITS  associated data block
req_data  input  DATA_BITS  plaintext/ciphertext block
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_data  output  DATA_BITS  core output data
rsp_tag  output  KEY_BITS  core tag
rsp_err  output  1  job aborted by watchdog (feature only, else tied 0)
busy  output  1  high in every state except IDLE
core_key_so, core_nonce_so, core_ad_so, core_data_so  output  1 each  serial lanes to core
core_start_so  output  1  one-cycle start pulse
core_decrypt_so  output  1  direction to core
core_data_si, core_tag_si, core_ready_si  input  1 each  serial results / ready from core

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 except req_ready=1; shift/capture registers and counter cleared. Reset mid-job abandons the job; no response is produced.
- States: IDLE, LOAD, START, WAIT, CAPTURE, DONE.
- IDLE: req_ready=1. On req_valid&req_ready (cycle T), latch all request fields, clear counter, go to LOAD. No other input is sampled.
- LOAD (cycles T+1..T+KEY_BITS, counter i=0..KEY_BITS-1):
  - core_key_so = key[KEY_BITS-1-i]; core_nonce_so = nonce[KEY_BITS-1-i] (MSB first).
  - ad/data lanes drive bit [DATA_BITS-1-i] while i<DATA_BITS, else 0.
  - After the last bit, go to START.
- START: core_start_so=1 for exactly one cycle (T+KEY_BITS+1); serial lanes 0; go to WAIT.
- core_decrypt_so holds the latched direction from LOAD through DONE; it is 0 in IDLE.
- WAIT: hold until core_ready_si=1. The cycle ready is first seen (C0) is capture bit 0; go to CAPTURE in the same cycle.
- CAPTURE (C0..C0+KEY_BITS-1, counter j):
  - tag shift register shifts left, inserting core_tag_si (first bit = MSB).
  - data shift register shifts in core_data_si only while j<DATA_BITS.
  - core_ready_si is ignored after C0; capture length is fixed.
- DONE (from C0+KEY_BITS): rsp_valid=1, rsp_data/rsp_tag stable. On rsp_valid&rsp_ready, go to IDLE next cycle; rsp_valid drops, rsp_data/rsp_tag keep their value until the next capture.
- rsp_ready held high before DONE: completes in the first DONE cycle. Response latency after C0 = KEY_BITS cycles.
- Counter width: $clog2(KEY_BITS)+1; it never wraps because every terminal count is checked explicitly.

Optional Feature:
- Macro ASCON_SEQ_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on START and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC with core_ready_si still 0: go to DONE with rsp_err=1 and rsp_data/rsp_tag all zeros.
  - rsp_err clears on the handshake.
- Undefined: WAIT waits forever; rsp_err is constant 0; no watchdog logic is synthesised.

Test Plan:
1. Reset during LOAD (bit 40) → all core_*_so=0 immediately, req_ready=1, busy=0, rsp_valid stays 0.
2. Encrypt job, key=0x000102..0F, nonce=0x101112..1F, ad=0xA5A5A5A5A5A5A5A5, data=0x0123456789ABCDEF → lane streams match MSB-first bits; ad/data lanes 0 for i=64..127; core_start_so high exactly at T+129; core_decrypt_so=0.
3. Model core raises ready 10 cycles after start and streams tag=0xFEDC..10, data=0x1122334455667788 → rsp_valid at C0+128 with matching rsp_tag/rsp_data.
4. rsp_ready held low for 5 DONE cycles, then pulsed → rsp_valid stays high with stable data for 5 cycles; busy=0 and req_ready=1 on the following cycle.
5. req_valid asserted while busy → req_ready=0 and job not taken; decrypt job offered after DONE is accepted, with core_decrypt_so=1 from LOAD through DONE.
6. With ASCON_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, ready never rises → DONE reached 16 cycles after WAIT entry, rsp_err=1, rsp_tag=0, rsp_data=0.
